// File: rtl/cfg_bitstream_loader_if.sv
// Parallel payload word stream feeding the config bitstream loader.
// The master offers words; the slave (loader) accepts on valid && ready.
interface cfg_bitstream_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/cfg_bitstream_loader.sv
// Serializes a frame of parallel words LSB-first into the fabric configuration
// daisy chain, framed by a start pulse up front and a done pulse at the end.
module cfg_bitstream_loader #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 crst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     total_bits,
  cfg_bitstream_loader_if.slave wif,
  output logic                 cfg_out_start,
  output logic                 cfg_bit_out,
  output logic                 cfg_bit_out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int WCNT_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FETCH,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [WORD_W-1:0]   sr_q, sr_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                start_q, start_d;
  logic                bit_q, bit_d;
  logic                vld_q, vld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ready;

  // Bits of the next word that belong to the frame; the rest are discarded.
  function automatic logic [WCNT_W-1:0] word_bits(input logic [LEN_W-1:0] rem);
    if (32'(rem) >= 32'(WORD_W)) return WCNT_W'(WORD_W);
    return WCNT_W'(rem);
  endfunction

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    sr_d        = sr_q;
    wcnt_d      = wcnt_q;
    ready       = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (total_bits != '0) begin
            remaining_d = total_bits;
            state_d     = S_START;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        ready = 1'b1;
        if (wif.word_valid) begin
          sr_d    = wif.word_in;
          wcnt_d  = word_bits(remaining_q);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d        = sr_q >> 1;
        wcnt_d      = wcnt_q - WCNT_W'(1);
        remaining_d = remaining_q - LEN_W'(1);
        if (remaining_q == LEN_W'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (wcnt_q == WCNT_W'(1)) begin
          // Prefetch on the last bit of a word keeps the stream bubble-free.
          ready = 1'b1;
          if (wif.word_valid) begin
            sr_d   = wif.word_in;
            wcnt_d = word_bits(remaining_q - LEN_W'(1));
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    start_d = (state_d == S_START);
    vld_d   = (state_d == S_SHIFT);
    bit_d   = vld_d & sr_d[0];
    busy_d  = (state_d == S_START) || (state_d == S_FETCH) || (state_d == S_SHIFT);
  end

  always_ff @(posedge clk or posedge crst) begin
    if (crst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      sr_q        <= '0;
      wcnt_q      <= '0;
      start_q     <= 1'b0;
      bit_q       <= 1'b0;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      sr_q        <= sr_d;
      wcnt_q      <= wcnt_d;
      start_q     <= start_d;
      bit_q       <= bit_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign wif.word_ready    = ready;
  assign cfg_out_start     = start_q;
  assign cfg_bit_out       = bit_q;
  assign cfg_bit_out_valid = vld_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: doc/cfg_bitstream_loader.md
Name: cfg_bitstream_loader

Overview:
- Upstream driver of the fabric configuration chain; feeds the serial config port of the first tile (switch boxes, CLBs) in the daisy chain.
- Accepts a frame length plus a stream of parallel words over a valid/ready handshake.
- Emits a one-cycle start pulse, then serializes the payload LSB-first as a bit stream with a per-bit valid, and signals completion.

Parameters:
- WORD_W, 32, width of the parallel payload words.
- LEN_W, 16, width of the frame bit-count; maximum frame length is 2^LEN_W-1 bits.

Ports:
- clk  input  1  single clock for all logic.
- crst  input  1  reset; asynchronous, active-high.
- start  input  1  one-cycle frame request; sampled only in IDLE.
- total_bits  input  LEN_W  frame payload length in bits; latched with start.
- word_in  input  WORD_W  payload word; bit 0 is shifted out first.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  loader accepts word_in this cycle; transfer occurs when word_valid && word_ready.
- cfg_out_start  output  1  one-cycle frame-start pulse to the chain.
- cfg_bit_out  output  1  serial config bit.
- cfg_bit_out_valid  output  1  cfg_bit_out is valid this cycle.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last bit of a frame (or immediately after a zero-length start).

Behaviour:
- All outputs except word_ready are registered. On crst: state=IDLE; cfg_out_start, cfg_bit_out, cfg_bit_out_valid, busy, done, and word_ready = 0; the remaining counter and the shift register are cleared.
- Reset mid-frame abandons the frame with no done pulse. The chain recovers on the next cfg_out_start.
- Registers: remaining[LEN_W] (bits left in the frame), sr[WORD_W], wcnt (bits left in the current word, range 0..WORD_W).
- IDLE:
  - start && total_bits!=0: latch remaining=total_bits; go to START; busy=1 next cycle.
  - start && total_bits==0: done=1 next cycle; stay in IDLE; no cfg_out_start.
- START (1 cycle): cfg_out_start=1; go to FETCH.
  - Latency: start at cycle 0 -> cfg_out_start high at cycle 1 -> earliest bit valid at cycle 3.
- FETCH:
  - word_ready=1 (combinational from state).
  - On transfer: sr=word_in; wcnt=min(WORD_W, remaining); go to SHIFT.
  - cfg_bit_out_valid=0 while waiting.
- SHIFT, each cycle:
  - cfg_bit_out_valid=1 and cfg_bit_out=sr[0]; sr shifts right; wcnt--; remaining--.
  - Prefetch: word_ready=1 in the last-bit-of-word cycle (wcnt==1) when remaining>1. A transfer in that cycle reloads sr/wcnt, and the next cycle shifts the new word's bit 0 (zero-bubble streaming).
  - Last bit of a word with no transfer and remaining>1: go to FETCH (stall, valid low).
  - Last bit of the frame (remaining==1): go to DONE; word_ready=0.
- DONE (1 cycle): done=1, busy=0 in the same registered cycle; go to IDLE.
- Partial last word: bits above (remaining mod WORD_W) are discarded, never emitted.
- No extra words are consumed beyond ceil(total_bits/WORD_W).
- start while busy is ignored.
- word_valid outside FETCH and the prefetch cycle is ignored.
- At most one transfer per cycle.

Test Plan:
- Basic frame: total_bits=40, words 0xDEADBEEF then 0x000000A5, word_valid always high -> one cfg_out_start pulse, then exactly 40 consecutive valid bits: 0xDEADBEEF LSB-first (1,1,1,1,0,1,1,1,...), then 1,0,1,0,0,1,0,1. No bubble between words. done pulses one cycle after the last bit. Exactly 2 words consumed.
- Stall: same frame, second word_valid delayed 5 cycles -> cfg_bit_out_valid low for exactly those stall cycles, bit order unchanged, done after bit 40.
- Zero length: start with total_bits=0 -> done pulse next cycle, no cfg_out_start, no word_ready, busy stays 0.
- Exact multiple: total_bits=64 with 3 words offered -> 64 bits emitted, third word not accepted (word_ready never high after the second transfer).
- Reset mid-frame: assert crst after bit 10 of a 96-bit frame -> all outputs 0 asynchronously, no done pulse. A following 8-bit frame of 0x3C emits 0,0,1,1,1,1,0,0.
- Start while busy: pulse start with total_bits=5 during a 40-bit frame -> ignored. Only the 40-bit frame completes, with a single done pulse.
